// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg-timer display path.
//   - conv_state_e : states of the seconds -> MM:SS conversion FSM
//   - SECS_PER_MIN, DEC_BASE : divisors used by the repeated-subtraction converter
//   - DEF_DIGIT_CYCLES, DEF_BLINK_CYCLES : default timing at the 5 MHz system clock
//   - SEG_BLANK, seg7_decode() : active-low seven-segment encoding (gfedcba)
package egg_timer_pkg;

    typedef enum logic [2:0] {
        CONV_IDLE,
        CONV_SUB60,
        CONV_SPLIT_M,
        CONV_SPLIT_S,
        CONV_DONE
    } conv_state_e;

    localparam int SECS_PER_MIN = 60;
    localparam int DEC_BASE     = 10;

    // 1 ms per digit and 0.5 s per blink half-period at 5 MHz.
    localparam int DEF_DIGIT_CYCLES = 5000;
    localparam int DEF_BLINK_CYCLES = 2500000;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit 6 = g .. bit 0 = a. Non-decimal codes go dark.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/mmss_converter.sv
// Converts a remaining-seconds count into four MM:SS decimal digits by
// repeated subtraction (one subtraction per clock).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   count_in      : remaining time in seconds
//   m_tens..s_units : digit registers, loaded together when a conversion completes
//   conv_done     : one-cycle pulse, high in the cycle after the digits load
//   state         : current conversion FSM state (debug visibility)
module mmss_converter
    import egg_timer_pkg::*;
#(
    parameter int COUNT_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count_in,
    output logic [3:0]         m_tens,
    output logic [3:0]         m_units,
    output logic [3:0]         s_tens,
    output logic [3:0]         s_units,
    output logic               conv_done,
    output conv_state_e        state
);

    localparam logic [COUNT_W-1:0] SEC_STEP = COUNT_W'(SECS_PER_MIN);
    localparam logic [COUNT_W-1:0] MIN_STEP = COUNT_W'(DEC_BASE);
    localparam logic [5:0]         SEC_DEC  = 6'(DEC_BASE);

    logic [COUNT_W-1:0] shadow;   // last value accepted for conversion
    logic [COUNT_W-1:0] work;     // seconds still to be divided by 60
    logic [COUNT_W-1:0] min_acc;  // whole minutes, then minute units
    logic [5:0]         sec_acc;  // leftover seconds, then second units
    logic [3:0]         mt_acc;
    logic [3:0]         st_acc;

    // count_in is only looked at in IDLE, so a value change mid-conversion
    // lets the in-flight result finish and is picked up on the next pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CONV_IDLE;
            shadow    <= '0;
            work      <= '0;
            min_acc   <= '0;
            sec_acc   <= '0;
            mt_acc    <= '0;
            st_acc    <= '0;
            m_tens    <= '0;
            m_units   <= '0;
            s_tens    <= '0;
            s_units   <= '0;
            conv_done <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            case (state)
                CONV_IDLE: begin
                    if (count_in != shadow) begin
                        shadow  <= count_in;
                        work    <= count_in;
                        min_acc <= '0;
                        sec_acc <= '0;
                        mt_acc  <= '0;
                        st_acc  <= '0;
                        state   <= CONV_SUB60;
                    end
                end
                CONV_SUB60: begin
                    if (work >= SEC_STEP) begin
                        work    <= work - SEC_STEP;
                        min_acc <= min_acc + COUNT_W'(1);
                    end else begin
                        sec_acc <= work[5:0];
                        state   <= CONV_SPLIT_M;
                    end
                end
                CONV_SPLIT_M: begin
                    if (min_acc >= MIN_STEP) begin
                        min_acc <= min_acc - MIN_STEP;
                        mt_acc  <= mt_acc + 4'd1;
                    end else begin
                        state <= CONV_SPLIT_S;
                    end
                end
                CONV_SPLIT_S: begin
                    if (sec_acc >= SEC_DEC) begin
                        sec_acc <= sec_acc - SEC_DEC;
                        st_acc  <= st_acc + 4'd1;
                    end else begin
                        state <= CONV_DONE;
                    end
                end
                CONV_DONE: begin
                    // All four digits change on the same edge: no partial value shows.
                    m_tens    <= mt_acc;
                    m_units   <= min_acc[3:0];
                    s_tens    <= st_acc;
                    s_units   <= sec_acc[3:0];
                    conv_done <= 1'b1;
                    state     <= CONV_IDLE;
                end
                default: state <= CONV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mmss_display_driver.sv
// Drives a 4-digit active-low seven-segment display with a MM.SS countdown.
// Ports:
//   clk, rst  : 5 MHz system clock, synchronous active-high reset
//   count_in  : remaining seconds from the countdown core
//   blank     : 1 = display dark (overrides blinking)
//   blink_en  : 1 = flash the display at BLINK_CYCLES per half-period
//   seg       : active-low segments, seg[6]=g .. seg[0]=a
//   an        : active-low anodes, an[0] = rightmost digit
//   dp        : active-low decimal point, lit on the minute-units digit
module mmss_display_driver
    import egg_timer_pkg::*;
#(
    parameter int COUNT_W      = 12,
    parameter int DIGIT_CYCLES = DEF_DIGIT_CYCLES,
    parameter int BLINK_CYCLES = DEF_BLINK_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               blank,
    input  logic               blink_en,
    output logic [6:0]         seg,
    output logic [3:0]         an,
    output logic               dp
);

    localparam int SCAN_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(DIGIT_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [3:0]   m_tens, m_units, s_tens, s_units;
    logic         unused_conv_done;
    conv_state_e  unused_conv_state;

    mmss_converter #(
        .COUNT_W (COUNT_W)
    ) u_conv (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .m_tens    (m_tens),
        .m_units   (m_units),
        .s_tens    (s_tens),
        .s_units   (s_units),
        .conv_done (unused_conv_done),
        .state     (unused_conv_state)
    );

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase_on;

    logic [BLINK_W-1:0] blink_cnt_next;
    logic               phase_next;
    logic [3:0]         digit_sel;
    logic               dark;

    always_comb begin
        blink_cnt_next = blink_cnt;
        phase_next     = phase_on;
        if (!blink_en) begin
            blink_cnt_next = '0;
            phase_next     = 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_on;
        end else begin
            blink_cnt_next = blink_cnt + BLINK_W'(1);
        end

        case (idx)
            2'd0:    digit_sel = s_units;
            2'd1:    digit_sel = s_tens;
            2'd2:    digit_sel = m_units;
            default: digit_sel = m_tens;
        endcase

        // Gating uses the next blink phase so the display follows a phase
        // toggle or a blink_en clear on the same edge rather than one later.
        dark = blank | ~phase_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx       <= 2'd0;
            blink_cnt <= '0;
            phase_on  <= 1'b1;
            an        <= 4'b1111;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end

            blink_cnt <= blink_cnt_next;
            phase_on  <= phase_next;

            // Outputs reflect the index held before this edge (one-cycle lag).
            an  <= dark ? 4'b1111   : ~(4'b0001 << idx);
            seg <= dark ? SEG_BLANK : seg7_decode(digit_sel);
            dp  <= dark | (idx != 2'd2);
        end
    end

endmodule

// File: tb/tb_mmss_display_driver.sv
module tb_mmss_display_driver;
    import egg_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] count_in;
    logic        blank;
    logic        blink_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int checks   = 0;
    int failures = 0;

    logic [15:0] digits_obs;

    mmss_display_driver #(
        .COUNT_W      (12),
        .DIGIT_CYCLES (4),
        .BLINK_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .blank    (blank),
        .blink_en (blink_en),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    assign digits_obs = {dut.u_conv.m_tens, dut.u_conv.m_units,
                         dut.u_conv.s_tens, dut.u_conv.s_units};

    // ---------------- driver / check tasks ----------------
    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step until the given anode pattern is driven (bounded), then record it.
    task automatic wait_an(input string tag, input logic [3:0] want);
        int n;
        n = 0;
        while (an !== want && n < 40) begin
            step(1);
            n++;
        end
        check(tag, 32'(an), 32'(want));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic bad;

        rst      = 1'b1;
        count_in = 12'd0;
        blank    = 1'b0;
        blink_en = 1'b0;

        // Reset held 3 cycles
        step(3);
        check("rst_an",  32'(an),  32'(4'b1111));
        check("rst_seg", 32'(seg), 32'(7'h7F));
        check("rst_dp",  32'(dp),  32'(1'b1));
        check("rst_digits", 32'(digits_obs), 32'(16'h0000));

        rst = 1'b0;
        step(1);
        check("post_rst_an",  32'(an),  32'(4'b1110));
        check("post_rst_seg", 32'(seg), 32'(7'b1000000));
        check("post_rst_dp",  32'(dp),  32'(1'b1));

        // 61 s -> 01.01, digits land on edge 6
        count_in = 12'd61;
        step(5);
        check("c61_before", 32'(digits_obs), 32'(16'h0000));
        step(1);
        check("c61_edge6", 32'(digits_obs), 32'(16'h0101));

        wait_an("c61_an0", 4'b1110);
        check("c61_seg0", 32'(seg), 32'(7'b1111001));
        check("c61_dp0",  32'(dp),  32'(1'b1));
        wait_an("c61_an1", 4'b1101);
        check("c61_seg1", 32'(seg), 32'(7'b1000000));
        wait_an("c61_an2", 4'b1011);
        check("c61_seg2", 32'(seg), 32'(7'b1111001));
        check("c61_dp2",  32'(dp),  32'(1'b0));
        wait_an("c61_an3", 4'b0111);
        check("c61_seg3", 32'(seg), 32'(7'b1000000));
        check("c61_dp3",  32'(dp),  32'(1'b1));

        // 4095 s -> 68.15 on edge 80, nothing partial before
        count_in = 12'd4095;
        bad = 1'b0;
        for (int i = 1; i <= 79; i++) begin
            step(1);
            if (digits_obs !== 16'h0101) bad = 1'b1;
        end
        check("c4095_no_partial", 32'(bad), 32'(1'b0));
        step(1);
        check("c4095_edge80", 32'(digits_obs), 32'(16'h6815));
        check("c4095_done_pulse", 32'(dut.u_conv.conv_done), 32'(1'b1));

        wait_an("c4095_an2", 4'b1011);
        check("c4095_seg2", 32'(seg), 32'(7'b0000000));
        check("c4095_dp2",  32'(dp),  32'(1'b0));
        wait_an("c4095_an3", 4'b0111);
        check("c4095_seg3", 32'(seg), 32'(7'b0000010));

        // 61 then 121 mid-conversion: 01.01 at edge 6, 02.01 at re-capture edge + 6
        count_in = 12'd61;
        step(2);
        count_in = 12'd121;
        step(3);
        check("chg_before", 32'(digits_obs), 32'(16'h6815));
        step(1);
        check("chg_edge6", 32'(digits_obs), 32'(16'h0101));
        step(6);
        check("chg_before2", 32'(digits_obs), 32'(16'h0101));
        step(1);
        check("chg_recapture7", 32'(digits_obs), 32'(16'h0201));

        // Blink: dark from cycle 16, lit from 32, dark from 48
        blink_en = 1'b1;
        step(15);
        check("blink_lit15", 32'(an != 4'b1111), 32'(1'b1));
        step(1);
        check("blink_dark16_an",  32'(an),  32'(4'b1111));
        check("blink_dark16_seg", 32'(seg), 32'(7'h7F));
        check("blink_dark16_dp",  32'(dp),  32'(1'b1));
        step(15);
        check("blink_dark31", 32'(an), 32'(4'b1111));
        step(1);
        check("blink_lit32", 32'(an != 4'b1111), 32'(1'b1));
        step(16);
        check("blink_dark48", 32'(an), 32'(4'b1111));
        blink_en = 1'b0;
        step(1);
        check("blink_clear_lit", 32'(an != 4'b1111), 32'(1'b1));

        // Blank forces dark on the next edge, priority over a lit blink phase
        blink_en = 1'b1;
        blank    = 1'b1;
        step(1);
        check("blank_an",  32'(an),  32'(4'b1111));
        check("blank_seg", 32'(seg), 32'(7'h7F));
        blank    = 1'b0;
        blink_en = 1'b0;
        step(1);
        check("unblank_lit", 32'(an != 4'b1111), 32'(1'b1));

        // Reset in the middle of a 4095 conversion
        count_in = 12'd4095;
        step(10);
        rst = 1'b1;
        step(1);
        check("midrst_an",     32'(an),         32'(4'b1111));
        check("midrst_digits", 32'(digits_obs), 32'(16'h0000));
        check("midrst_state",  32'(dut.u_conv.state), 32'(CONV_IDLE));
        rst = 1'b0;
        step(79);
        check("midrst_before80", 32'(digits_obs), 32'(16'h0000));
        step(1);
        check("midrst_edge80", 32'(digits_obs), 32'(16'h6815));

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Backstop in case a wait misbehaves
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mmss_display_driver.md
Name: mmss_display_driver

Overview:
- Downstream consumer of the egg-timer countdown value: converts the 12-bit remaining-seconds count into MM:SS digits.
- Time-multiplexes the digits onto the 4-digit active-low seven-segment display.
- Sits between the countdown/FSM core and the board pins (seg, an, dp), clocked by the 5 MHz system clock.
- Supports forced blanking, and flashing when the timer expires.

Parameters:
- COUNT_W, 12, width of the seconds count input.
- DIGIT_CYCLES, 5000, clocks each digit is driven (1 ms at 5 MHz).
- BLINK_CYCLES, 2500000, clocks per blink half-period (0.5 s at 5 MHz).

Ports:
- clk  in  1  system clock, 5 MHz.
- rst  in  1  synchronous, active-high reset.
- count_in  in  COUNT_W  remaining time in seconds, 0..4095.
- blank  in  1  1 = display dark.
- blink_en  in  1  1 = flash display (timer done).
- seg  out  7  active-low segments, seg[6]=g .. seg[0]=a.
- an  out  4  active-low anodes, an[0] = rightmost digit.
- dp  out  1  active-low decimal point, used as the MM.SS separator.

Behaviour:
- All state changes on posedge clk. rst is sampled synchronously only.
- Reset values:
  - an=4'b1111, seg=7'h7F, dp=1.
  - Conversion FSM in IDLE; shadow=0.
  - Digit registers (m_tens, m_units, s_tens, s_units) = 0.
  - Scan counter = 0, digit index = 0, blink counter = 0, blink phase = on.
- Conversion FSM states: IDLE, SUB60, SPLIT_M, SPLIT_S, DONE.
  - IDLE: if count_in != shadow, capture shadow=count_in and work=count_in, clear min/sec/tens accumulators, go to SUB60. Otherwise stay.
  - SUB60: if work>=60, then work-=60 and min+=1 (one subtraction per cycle). Else sec=work, go to SPLIT_M.
  - SPLIT_M: if min>=10, then min-=10 and mt+=1. Else go to SPLIT_S.
  - SPLIT_S: if sec>=10, then sec-=10 and st+=1. Else go to DONE.
  - DONE: load all four digit registers atomically from mt/min/st/sec, go to IDLE.
- Latency: digit registers update on edge 5+q60+qm+qs, where edge 1 is the IDLE capture.
  - q60 = count/60; qm = minutes/10; qs = seconds/10.
  - Worst case is 4095 → 68:15: 80 edges.
- count_in changes during conversion are ignored. The in-flight result still completes; IDLE then sees count_in != shadow and reconverts. No partial value is ever displayed.
- Minutes reach at most 68, so they always fit in two digits. No saturation logic is needed.
- Scan:
  - Scan counter runs 0..DIGIT_CYCLES-1. On wrap, the digit index increments 0→1→2→3→0.
  - Index 0 = s_units, 1 = s_tens, 2 = m_units, 3 = m_tens.
  - an = ~(4'b0001 << idx).
  - dp=0 only when idx==2; otherwise dp=1.
  - seg = decode(selected digit).
  - seg/an/dp are registered, so they lag the index by 1 cycle.
- Decode (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blink:
  - blink_en=0: blink counter held at 0, phase = on.
  - blink_en=1: counter runs; at BLINK_CYCLES-1 it wraps and phase toggles. The first toggle (to off) occurs BLINK_CYCLES cycles after blink_en rises.
- Output gating: when blank=1 or phase=off, the registered outputs are an=4'b1111, seg=7'h7F, dp=1. Scan and conversion continue running underneath. blank has priority over blink.
- Reset mid-conversion: the FSM aborts to IDLE and digits clear to 0. If count_in != 0 after reset, a fresh conversion starts.

Decomposition:
- Shared package egg_timer_pkg:
  - Conversion state enum.
  - Constants SECS_PER_MIN=60 and DEC_BASE=10.
  - 10-entry active-low segment table / seg7_decode function.
  - Default 5 MHz timing constants.
- Sub-module mmss_converter: holds the conversion FSM and digit registers.
  - Inputs: clk, rst, count_in.
  - Outputs: four 4-bit digits plus a one-cycle conv_done pulse.
- mmss_display_driver instantiates mmss_converter and owns the scan, blink and output registers.

Test Plan:
Use DIGIT_CYCLES=4 and BLINK_CYCLES=16.
- Reset: rst=1 for 3 cycles → an=1111, seg=7F, dp=1. After release, idx0 is driven with an=1110, seg=1000000.
- count_in=0→61 → digits update on edge 6. Scan shows an=1110 seg=1111001, 1101 seg=1000000, 1011 seg=1111001 dp=0, 0111 seg=1000000 ("01.01").
- count_in=4095 → digits update on edge 80 as 6,8,1,5. No intermediate digit values are visible before edge 80.
- count_in=61, then changed to 121 at edge 3 → 01.01 latched at edge 6, then 02.01 latched 7 edges after re-capture.
- blink_en=1 → outputs dark for cycles 16..31, lit for 32..47, and so on. blank=1 at any time → an=1111 immediately on the next edge. Clearing blink_en restores the lit display on the next edge.
- rst asserted during a 4095 conversion → digits=0 and an=1111 on the next edge. After release, 68.15 reappears 80 edges after re-capture.
